// File: rtl/intr_timer_if.sv
// Interrupt/CP0 snoop bundle between the core-side CP0 logic (master) and intr_timer (slave).
// W_HINT is the width of the external interrupt and hard_intr vectors.
interface intr_timer_if #(
   parameter int W_HINT = 6
);
   logic [W_HINT-1:0] ext_intr;
   logic              wr_en;
   logic [4:0]        wr_regf;
   logic [31:0]       wr_data;
   logic              exc_we;
   logic [W_HINT-1:0] hard_intr;
   logic [31:0]       count_o;
   logic [31:0]       compare_o;
   logic              timer_pending;

   modport master (
      output ext_intr, wr_en, wr_regf, wr_data, exc_we,
      input  hard_intr, count_o, compare_o, timer_pending
   );

   modport slave (
      input  ext_intr, wr_en, wr_regf, wr_data, exc_we,
      output hard_intr, count_o, compare_o, timer_pending
   );
endinterface

// File: rtl/intr_timer.sv
// MIPS interrupt front end: ext line sync + glitch filter, CP0 Count/Compare timer.
// Timer logic is present only when TIMER_INTR_EN is defined; otherwise its outputs tie to 0.
module intr_timer #(
   parameter int FILT_CYC = 4,
   parameter int CNT_DIV  = 2
) (
   input logic         clk,
   input logic         rst,
   intr_timer_if.slave bus
);
   localparam int         W_HINT   = 6;
   localparam logic [7:0] FILT_LIM = 8'(FILT_CYC - 1);

   logic [W_HINT-1:0] s1_q, s1_d;
   logic [W_HINT-1:0] s2_q, s2_d;
   logic [W_HINT-1:0] f_q, f_d;
   logic [7:0]        c_q [W_HINT];
   logic [7:0]        c_d [W_HINT];
   logic              timer_bit;

   // A line's filtered value flips only after FILT_CYC consecutive disagreeing samples.
   always_comb begin
      s1_d = bus.ext_intr;
      s2_d = s1_q;
      f_d  = f_q;
      for (int i = 0; i < W_HINT; i++) begin
         c_d[i] = c_q[i];
         if (s2_q[i] == f_q[i]) begin
            c_d[i] = 8'd0;
         end else if (c_q[i] == FILT_LIM) begin
            f_d[i] = s2_q[i];
            c_d[i] = 8'd0;
         end else begin
            c_d[i] = c_q[i] + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         f_q  <= '0;
         for (int i = 0; i < W_HINT; i++) begin
            c_q[i] <= 8'd0;
         end
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         f_q  <= f_d;
         for (int i = 0; i < W_HINT; i++) begin
            c_q[i] <= c_d[i];
         end
      end
   end

`ifdef TIMER_INTR_EN
   localparam logic [7:0] DIV_LIM = 8'(CNT_DIV - 1);

   logic        wr_eff, wr_count, wr_cmp, tick;
   logic [7:0]  p_q, p_d;
   logic [31:0] count_q, count_d, count_inc;
   logic [31:0] compare_q, compare_d;
   logic        pend_q, pend_d;

   // Count writes realign the prescaler; a Compare write always wins over a same-edge match.
   always_comb begin
      wr_eff    = bus.wr_en & ~bus.exc_we;
      wr_count  = wr_eff && (bus.wr_regf == 5'd9);
      wr_cmp    = wr_eff && (bus.wr_regf == 5'd11);
      tick      = (p_q == DIV_LIM);
      count_inc = count_q + 32'd1;
      p_d       = (tick || wr_count) ? 8'd0 : p_q + 8'd1;
      count_d   = count_q;
      if (wr_count) begin
         count_d = bus.wr_data;
      end else if (tick) begin
         count_d = count_inc;
      end
      compare_d = wr_cmp ? bus.wr_data : compare_q;
      pend_d    = pend_q;
      if (wr_cmp) begin
         pend_d = 1'b0;
      end else if (tick && !wr_count && (count_inc == compare_q)) begin
         pend_d = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         p_q       <= 8'd0;
         count_q   <= 32'd0;
         compare_q <= 32'd0;
         pend_q    <= 1'b0;
      end else begin
         p_q       <= p_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
      end
   end

   assign bus.count_o       = count_q;
   assign bus.compare_o     = compare_q;
   assign bus.timer_pending = pend_q;
   assign timer_bit         = pend_q;
`else
   assign bus.count_o       = 32'd0;
   assign bus.compare_o     = 32'd0;
   assign bus.timer_pending = 1'b0;
   assign timer_bit         = 1'b0;
`endif

   assign bus.hard_intr = {f_q[5] | timer_bit, f_q[4:0]};
endmodule

// File: tb/tb_intr_timer.sv
// Randomized + directed bench for intr_timer against a cycle-indexed behavioural model.
// Timer expectations follow TIMER_INTR_EN, matching whichever build of the RTL is compiled.
module tb_intr_timer;
   localparam int FILT_CYC = 4;
   localparam int CNT_DIV  = 2;
`ifdef TIMER_INTR_EN
   localparam bit TIMER_ON = 1'b1;
`else
   localparam bit TIMER_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;

   intr_timer_if bus ();

   intr_timer #(.FILT_CYC(FILT_CYC), .CNT_DIV(CNT_DIV)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Model: ext samples indexed by edge number since reset release, plus timer state.
   logic [5:0]  hist [4096];
   int          edge_n;
   int          anchor;
   logic [5:0]  m_f;
   logic [31:0] m_count;
   logic [31:0] m_compare;
   logic        m_pend;
   logic [5:0]  cur_ext;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [5:0] samp(input int k);
      return (k <= 0) ? 6'd0 : hist[k % 4096];
   endfunction

   task automatic modelReset();
      edge_n    = 0;
      anchor    = 0;
      m_f       = 6'd0;
      m_count   = 32'd0;
      m_compare = 32'd0;
      m_pend    = 1'b0;
   endtask

   // A line flips once the last FILT_CYC values seen at the filter input all disagree with it.
   task automatic modelEdge(input logic [5:0] ext, input logic wen, input logic [4:0] regf,
                            input logic [31:0] data, input logic exc);
      logic [5:0] nf;
      logic [5:0] s;
      bit         all_diff;
      bit         wr9, wr11, tick;
      edge_n++;
      hist[edge_n % 4096] = ext;
      nf = m_f;
      for (int i = 0; i < 6; i++) begin
         all_diff = 1'b1;
         for (int j = 0; j < FILT_CYC; j++) begin
            s = samp(edge_n - 2 - j);
            if (s[i] == m_f[i]) all_diff = 1'b0;
         end
         if (all_diff) nf[i] = ~m_f[i];
      end
      m_f  = nf;
      wr9  = wen && !exc && (regf == 5'd9);
      wr11 = wen && !exc && (regf == 5'd11);
      tick = !wr9 && (((edge_n - anchor) % CNT_DIV) == 0);
      if (wr9) begin
         m_count = data;
         anchor  = edge_n;
      end else if (tick) begin
         m_count = m_count + 32'd1;
      end
      if (wr11) m_pend = 1'b0;
      else if (tick && (m_count == m_compare)) m_pend = 1'b1;
      if (wr11) m_compare = data;
   endtask

   task automatic checkAll();
      logic [31:0] e_cnt, e_cmp;
      logic        e_pend;
      e_cnt  = TIMER_ON ? m_count : 32'd0;
      e_cmp  = TIMER_ON ? m_compare : 32'd0;
      e_pend = TIMER_ON ? m_pend : 1'b0;
      checkOutput("hard_intr", {26'd0, bus.hard_intr}, {26'd0, m_f[5] | e_pend, m_f[4:0]});
      checkOutput("count_o", bus.count_o, e_cnt);
      checkOutput("compare_o", bus.compare_o, e_cmp);
      checkOutput("timer_pending", {31'd0, bus.timer_pending}, {31'd0, e_pend});
   endtask

   task automatic applyStimulus(input logic [5:0] ext, input logic wen, input logic [4:0] regf,
                                input logic [31:0] data, input logic exc);
      @(negedge clk);
      bus.ext_intr = ext;
      bus.wr_en    = wen;
      bus.wr_regf  = regf;
      bus.wr_data  = data;
      bus.exc_we   = exc;
      @(posedge clk);
      modelEdge(ext, wen, regf, data, exc);
      #1;
      checkAll();
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) applyStimulus(cur_ext, 1'b0, 5'd0, 32'd0, 1'b0);
   endtask

   task automatic wrReg(input logic [4:0] regf, input logic [31:0] data);
      applyStimulus(cur_ext, 1'b1, regf, data, 1'b0);
   endtask

   task automatic holdExt(input logic [5:0] ext, input int n);
      cur_ext = ext;
      idle(n);
   endtask

   initial begin
      logic [4:0]  regf;
      logic [31:0] data;
      logic        wen, exc;
      int          sel;

      bus.ext_intr = 6'd0;
      bus.wr_en    = 1'b0;
      bus.wr_regf  = 5'd0;
      bus.wr_data  = 32'd0;
      bus.exc_we   = 1'b0;
      cur_ext      = 6'd0;
      modelReset();
      #12;
      checkAll();
      @(negedge clk);
      rst = 1'b0;

      // Free run from reset.
      idle(2);
      checkOutput("free_cnt_e2", bus.count_o, TIMER_ON ? 32'd1 : 32'd0);
      idle(8);
      checkOutput("free_cnt_e10", bus.count_o, TIMER_ON ? 32'd5 : 32'd0);
      checkOutput("free_pend", {31'd0, bus.timer_pending}, 32'd0);

      // Filter: short pulse rejected, long hold passes with 6-edge latency both ways.
      holdExt(6'h04, 3);
      holdExt(6'h00, 8);
      checkOutput("pulse_reject", {31'd0, bus.hard_intr[2]}, 32'd0);
      holdExt(6'h04, 5);
      checkOutput("rise_e5", {31'd0, bus.hard_intr[2]}, 32'd0);
      holdExt(6'h04, 1);
      checkOutput("rise_e6", {31'd0, bus.hard_intr[2]}, 32'd1);
      holdExt(6'h04, 4);
      holdExt(6'h00, 5);
      checkOutput("fall_e5", {31'd0, bus.hard_intr[2]}, 32'd1);
      holdExt(6'h00, 1);
      checkOutput("fall_e6", {31'd0, bus.hard_intr[2]}, 32'd0);

      // Match.
      wrReg(5'd11, 32'h10);
      wrReg(5'd9, 32'h0E);
      idle(3);
      checkOutput("match_early", {31'd0, bus.timer_pending}, 32'd0);
      idle(1);
      checkOutput("match_cnt", bus.count_o, TIMER_ON ? 32'h10 : 32'd0);
      checkOutput("match_pend", {31'd0, bus.timer_pending}, {31'd0, TIMER_ON});
      checkOutput("match_hint5", {31'd0, bus.hard_intr[5]}, {31'd0, TIMER_ON});
      wrReg(5'd11, 32'h40);
      checkOutput("cmp_clear", {31'd0, bus.timer_pending}, 32'd0);

      // Wrap, then equal write.
      wrReg(5'd11, 32'd0);
      wrReg(5'd9, 32'hFFFF_FFFF);
      idle(2);
      checkOutput("wrap_cnt", bus.count_o, 32'd0);
      checkOutput("wrap_pend", {31'd0, bus.timer_pending}, {31'd0, TIMER_ON});
      wrReg(5'd11, 32'h50);
      wrReg(5'd9, 32'h50);
      idle(6);
      checkOutput("eq_write_pend", {31'd0, bus.timer_pending}, 32'd0);

      // Suppressed write, then Compare write colliding with a matching tick.
      wrReg(5'd11, 32'h60);
      wrReg(5'd9, 32'h5F);
      idle(2);
      applyStimulus(cur_ext, 1'b1, 5'd11, 32'h1234, 1'b1);
      checkOutput("supp_cmp", bus.compare_o, TIMER_ON ? 32'h60 : 32'd0);
      checkOutput("supp_pend", {31'd0, bus.timer_pending}, {31'd0, TIMER_ON});
      wrReg(5'd11, 32'h71);
      wrReg(5'd9, 32'h70);
      idle(1);
      wrReg(5'd11, 32'h71);
      checkOutput("coll_cnt", bus.count_o, TIMER_ON ? 32'h71 : 32'd0);
      checkOutput("coll_pend", {31'd0, bus.timer_pending}, 32'd0);

      // Asynchronous reset with pending set and a partial filter edge in flight.
      wrReg(5'd11, 32'h81);
      wrReg(5'd9, 32'h80);
      idle(2);
      holdExt(6'h3F, 3);
      @(negedge clk);
      #2 rst = 1'b1;
      #1;
      modelReset();
      checkOutput("rst_hint", {26'd0, bus.hard_intr}, 32'd0);
      checkOutput("rst_cnt", bus.count_o, 32'd0);
      checkOutput("rst_cmp", bus.compare_o, 32'd0);
      checkOutput("rst_pend", {31'd0, bus.timer_pending}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      cur_ext = 6'd0;
      idle(CNT_DIV - 1);
      checkOutput("rst_cnt_pre", bus.count_o, 32'd0);
      idle(1);
      checkOutput("rst_cnt_first", bus.count_o, TIMER_ON ? 32'd1 : 32'd0);

      // Randomized traffic, writes biased toward values near Count to provoke matches.
      for (int n = 0; n < 1500; n++) begin
         for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 7) == 0) cur_ext[i] = ~cur_ext[i];
         end
         wen = ($urandom_range(0, 4) == 0);
         exc = ($urandom_range(0, 7) == 0);
         sel = $urandom_range(0, 3);
         regf = (sel == 0) ? 5'd9 : (sel == 1) ? 5'd11 : 5'($urandom_range(1, 31));
         sel = $urandom_range(0, 3);
         if (sel == 0) data = m_count + 32'($urandom_range(0, 8));
         else if (sel == 1) data = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
         else data = $urandom;
         applyStimulus(cur_ext, wen, regf, data, exc);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/intr_timer.md
# intr_timer

Interrupt front end for the MIPS core. It conditions the six external hardware interrupt lines, with a synchronizer and a per-line glitch filter. It also implements the architectural Count/Compare timer (CP0 registers 9 and 11) and drives the `hard_intr` vector that the CP0 register file samples into Cause.IP[7:2]. It snoops the same CP0 write port as the register file, so software writes to Count/Compare take effect here.

## Interface
- `FILT_CYC`, default 4: consecutive stable cycles required before a filtered line changes; legal range 1..255, where 1 means no filtering.
- `CNT_DIV`, default 2: core cycles per Count increment; legal range 1..255.
- `clk` in 1: core clock.
- `rst` in 1: asynchronous, active-high reset.
- `ext_intr` in 6: raw external interrupt lines, asynchronous to `clk`.
- `wr_en` in 1: CP0 software write strobe, i.e. the register-file write with a nonzero register index.
- `wr_regf` in 5: CP0 register index of the write.
- `wr_data` in 32: CP0 write data.
- `exc_we` in 1: exception update to CP0 in progress; while high, the software write is suppressed.
- `hard_intr` out 6 (`W_HINT`): conditioned interrupt vector to CP0.
- `count_o` out 32: current Count value, muxed onto CP0 reads of register 9.
- `compare_o` out 32: current Compare value, muxed onto CP0 reads of register 11.
- `timer_pending` out 1: timer interrupt request, Cause.TI.

## Operation
- Effective write: `wr_eff = wr_en & ~exc_we`.
- Synchronizer:
  - Two flops per line: `s1 <= ext_intr`, `s2 <= s1`.
- Filter, per line `i`:
  - State: filtered bit `f[i]` and an 8-bit counter `c[i]`.
  - If `s2[i] == f[i]`: `c[i] <= 0`.
  - Else if `c[i] == FILT_CYC-1`: `f[i] <= s2[i]`, `c[i] <= 0`.
  - Else: `c[i] <= c[i]+1`.
  - A pulse on `s2` shorter than `FILT_CYC` cycles never reaches `f`.
- Prescaler `p`, 8 bits:
  - `tick = (p == CNT_DIV-1)`.
  - On tick, `p <= 0`; otherwise `p <= p+1`.
  - Any effective write to register 9 forces `p <= 0`.
- Count update, in priority order:
  1. Effective write to register 9: `count <= wr_data`.
  2. Otherwise, on tick: `count <= count+1`. Modulo 2^32, so 0xFFFFFFFF wraps to 0.
- Compare:
  - Effective write to register 11: `compare <= wr_data`.
- Timer pending, in priority order:
  1. Effective write to register 11: `timer_pending <= 0`. This applies even if the same cycle's increment would match.
  2. Otherwise, on a tick where there is no register-9 write and `count+1 == compare`: `timer_pending <= 1`.
  3. Otherwise: hold.
  - Writing Count equal to Compare does not set pending. Only an increment reaching Compare does.
- Output:
  - `hard_intr = f`, with `hard_intr[5] = f[5] | timer_pending`.
  - This is combinational from registers. CP0 registers `hard_intr` again.
- Writes to other register indices are ignored by this block.

## Timing
- Reset, asynchronous, with every register cleared:
  - s1, s2, f, c, p, count, compare, timer_pending are all 0.
  - Therefore `hard_intr`, `count_o`, `compare_o` and `timer_pending` are all 0.
- Reset asserted mid-operation:
  - A partially filtered edge is discarded.
  - Pending is lost.
  - Count restarts from 0 with prescaler phase 0 after release.
- `ext_intr` to `hard_intr` latency:
  - 2 edges to reach `s2`, plus `FILT_CYC` edges.
  - With `FILT_CYC=4`, a level held from before edge k is visible on `hard_intr` after edge k+5.
  - The deassert path has the same latency.
- Count rate:
  - After reset release, the first increment occurs at the `CNT_DIV`th edge, and then every `CNT_DIV` edges.
- Count write latency:
  - A write to register 9 at edge n makes `count_o = wr_data` after edge n.
  - The next increment follows `CNT_DIV` edges later.
- Timer interrupt latency:
  - Pending and the matching Count value appear after the same edge.
  - `hard_intr[5]` rises combinationally in that same cycle.
- Compare write latency:
  - A write to register 11 clears pending at the write edge, so `hard_intr[5]` falls the next cycle unless `f[5]` is high.
- `exc_we` and `wr_en` high together: no Count/Compare/pending change from the write path. Ticks still proceed.

## Configuration
- `TIMER_INTR_EN` defined:
  - Timer as described.
  - Pending is ORed into `hard_intr[5]`.
- `TIMER_INTR_EN` undefined:
  - Prescaler, count, compare and pending logic are removed.
  - `count_o`, `compare_o` and `timer_pending` are tied to 0.
  - `hard_intr[5] = f[5]`.
  - Writes to registers 9 and 11 are ignored.
  - The synchronizer and filter are unchanged.

## Test plan
- Filter:
  - Stimulus, `FILT_CYC=4`: `ext_intr[2]` pulsed high 3 cycles, then later held high 10 cycles.
  - Response: no change on the pulse; `hard_intr[2]` rises 6 edges after the hold starts and falls 6 edges after release.
- Free run, `CNT_DIV=2`, from reset with no writes:
  - `count_o` reads 1 after edge 2 and 5 after edge 10.
  - `timer_pending` stays 0.
- Match:
  - Stimulus: write Compare=0x10, then Count=0x0E.
  - Response: pending rises on the edge where `count_o` becomes 0x10; `hard_intr[5]=1`.
  - Stimulus: write Compare=0x40.
  - Response: pending is 0 after that edge.
- Wrap and equal write:
  - Stimulus: write Count=0xFFFFFFFF with Compare=0.
  - Response: the next tick gives `count_o=0` and pending 1.
  - Stimulus: write Count=Compare.
  - Response: pending stays 0.
- Suppression and collision:
  - Stimulus: `exc_we=1` and `wr_en=1` with `wr_regf=11`.
  - Response: compare and pending are unchanged.
  - Stimulus: Compare write on the same edge as a matching tick.
  - Response: pending is 0.
- Reset mid-filter and mid-pending:
  - Stimulus: assert `rst` for one cycle asynchronously, between edges.
  - Response: all outputs read 0 immediately; count restarts and reaches 1 at the `CNT_DIV`th edge after release.
